// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control FSM: state codes,
// opcodes, ALUControl codes, datapath select codes and small decode helpers.
package mc_ctrl_pkg;

    // FSM state codes (4-bit, legacy-compatible constants)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    // Supported opcodes
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation class handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Moore control bundle produced by the output decode
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic       illegal;
    } ctrl_t;

    // Immediate format implied by an opcode (I format for anything without one)
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:     imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

    // True when the opcode belongs to the supported subset
    function automatic logic op_is_known(input logic [6:0] op);
        logic known;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: known = 1'b1;
            default:                                             known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_ctrl_decode.sv
// ALU control decoder: turns the FSM's ALU operation class plus the funct
// fields into the 3-bit ALUControl code and flags unsupported funct3 values.
module alu_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    // Decode ALUControl; funct7_5 only selects subtract for register-register ops
    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        if (i_op5 && i_funct7_5) begin
                            o_alu_control = ALU_SUB;
                        end else begin
                            o_alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: begin
                        o_alu_control = ALU_ADD;
                        o_illegal     = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM. Registered state, Moore-style output decode
// of the state (plus funct/zero/mem_ready where a state's action depends on
// them). Write enables are forced low while reset is asserted so that an
// abandoned instruction never completes a pending write.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    ctrl_t      w_ctrl;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_control;
    logic       w_alu_illegal;
    logic       w_mem_done;
    logic       w_exec_state;

    // With a one-cycle memory every memory access completes immediately
    assign w_mem_done   = (MEM_HANDSHAKE == 32'sd0) ? 1'b1 : mem_ready;
    assign w_exec_state = (r_state == S_EXEC_R) || (r_state == S_EXEC_I);

    alu_ctrl_decode u_alu_ctrl_decode (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7_5),
        .i_op5         (op[5]),
        .o_alu_control (w_alu_control),
        .o_illegal     (w_alu_illegal)
    );

    // State register; reset abandons any instruction and returns to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ALU operation class depends on the state alone
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            S_EXEC_R, S_EXEC_I: w_alu_op = ALUOP_FUNCT;
            S_BRANCH:           w_alu_op = ALUOP_SUB;
            default:            w_alu_op = ALUOP_ADD;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (w_mem_done) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC_R;
                    OP_ITYPE:     w_next_state = S_EXEC_I;
                    OP_BRANCH:    w_next_state = S_BRANCH;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else if (op == OP_SW) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMREAD: begin
                if (w_mem_done) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (w_mem_done) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                // Unsupported funct3 skips writeback entirely
                if (w_alu_illegal) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_ALUWB;
                end
            end
            S_JAL:   w_next_state = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Output decode; selects not used by a state stay at 00
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.ir_write   = w_mem_done;
                w_ctrl.pc_write   = w_mem_done;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed into ALUOut here
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = imm_src_of(op);
                w_ctrl.illegal   = ~op_is_known(op);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = imm_src_of(op);
            end
            S_MEMREAD: begin
                w_ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays high for the whole wait on mem_ready
                w_ctrl.adr_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.illegal   = w_alu_illegal;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = imm_src_of(op);
                w_ctrl.illegal   = w_alu_illegal;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.result_src = RES_ALUOUT;
                if (funct3 == 3'b000) begin
                    w_ctrl.pc_write = zero;
                end else if (funct3 == 3'b001) begin
                    w_ctrl.pc_write = ~zero;
                end else begin
                    w_ctrl.illegal = 1'b1;
                end
            end
            S_JAL: begin
                // PC <- target from ALUOut while the ALU forms OldPC+4 for rd
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign pc_write    = w_ctrl.pc_write  & ~reset;
    assign mem_write   = w_ctrl.mem_write & ~reset;
    assign ir_write    = w_ctrl.ir_write  & ~reset;
    assign reg_write   = w_ctrl.reg_write & ~reset;
    assign illegal_op  = w_ctrl.illegal   & ~reset;
    assign adr_src     = w_ctrl.adr_src;
    assign result_src  = w_ctrl.result_src;
    assign alu_src_a   = w_ctrl.alu_src_a;
    assign alu_src_b   = w_ctrl.alu_src_b;
    assign imm_src     = w_ctrl.imm_src;
    assign alu_control = w_alu_control;

endmodule
